// File: rtl/mon_exp_unit.sv
// Montgomery square-and-multiply exponentiation engine and its
// dual-write-port operand memory.
module bram #(
   parameter int ABITS = 8,
   parameter int DBITS = 512
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ABITS-1:0] WR_ADDR1,
   input  logic [DBITS-1:0] WR_DATA1,
   input  logic             WR_EN1,
   input  logic [ABITS-1:0] WR_ADDR2,
   input  logic [DBITS-1:0] WR_DATA2,
   input  logic             WR_EN2,
   input  logic [ABITS-1:0] RD_ADDR,
   output logic [DBITS-1:0] RD_DATA
);

   logic [DBITS-1:0] mem [2**ABITS];

   // port 1 is written last so it wins on an address collision
   always_ff @(posedge clk) begin
      if (WR_EN2) mem[WR_ADDR2] <= WR_DATA2;
      if (WR_EN1) mem[WR_ADDR1] <= WR_DATA1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) RD_DATA <= '0;
      else     RD_DATA <= mem[RD_ADDR];
   end

endmodule

module mon_exp_unit #(
   parameter int bitLen = 1024,
   parameter int ABITS  = 8,
   parameter int DBITS  = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [bitLen-1:0] e,
   input  logic [9:0]        e_idx,
   input  logic [bitLen-1:0] M,
   input  logic [9:0]        mp_count,
   output logic [ABITS-1:0]  rd_addr,
   input  logic [DBITS-1:0]  rd_data,
   output logic [ABITS-1:0]  wr_addr,
   output logic [DBITS-1:0]  wr_data,
   output logic              wr_en,
   output logic              stop,
   output logic [bitLen:0]   ans
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SQR, S_MUL, S_FIN, S_WR, S_DONE
   } state_t;

   state_t state;

   logic [2:0]        ld_cnt;
   logic              wr_ph;
   logic [bitLen-1:0] e_r;
   logic [bitLen-1:0] m_r;
   logic [9:0]        k_r;
   logic [9:0]        i_r;
   logic [9:0]        j_r;
   logic [bitLen-1:0] x_r;
   logic [bitLen-1:0] mb_r;
   logic [bitLen+1:0] s_r;

   logic [bitLen-1:0] b_op;
   logic [bitLen+1:0] m_ext;
   logic [bitLen+1:0] t_sum;
   logic [bitLen+1:0] u_sum;
   logic [bitLen+1:0] s_nxt;
   logic [bitLen-1:0] red;
   logic              mp_last;
   logic              last_bit;

   // A is always X; only the B operand changes between products
   always_comb begin
      b_op = x_r;
      if (state == S_MUL)      b_op = mb_r;
      else if (state == S_FIN) b_op = {{(bitLen-1){1'b0}}, 1'b1};
   end

   assign m_ext    = {2'b00, m_r};
   assign t_sum    = s_r + (x_r[j_r] ? {2'b00, b_op} : '0);
   assign u_sum    = t_sum + (t_sum[0] ? m_ext : '0);
   assign s_nxt    = u_sum >> 1;
   assign red      = bitLen'((s_r >= m_ext) ? s_r - m_ext : s_r);
   assign mp_last  = (j_r == k_r);
   assign last_bit = (i_r == 10'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         ld_cnt  <= '0;
         wr_ph   <= 1'b0;
         e_r     <= '0;
         m_r     <= '0;
         k_r     <= '0;
         i_r     <= '0;
         j_r     <= '0;
         x_r     <= '0;
         mb_r    <= '0;
         s_r     <= '0;
         rd_addr <= '0;
         wr_addr <= '0;
         wr_data <= '0;
         wr_en   <= 1'b0;
         stop    <= 1'b0;
         ans     <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  e_r     <= e;
                  m_r     <= M;
                  k_r     <= mp_count;
                  i_r     <= e_idx;
                  j_r     <= '0;
                  s_r     <= '0;
                  ld_cnt  <= '0;
                  rd_addr <= '0;
                  stop    <= 1'b0;
                  state   <= S_LOAD;
               end
            end
            S_LOAD: begin
               ld_cnt <= ld_cnt + 3'd1;
               if (ld_cnt < 3'd3) rd_addr <= rd_addr + ABITS'(1);
               // read data trails the address by one cycle
               unique case (ld_cnt)
                  3'd1: x_r[DBITS-1:0] <= rd_data;
                  3'd2: x_r[bitLen-1 -: DBITS] <= rd_data;
                  3'd3: mb_r[DBITS-1:0] <= rd_data;
                  3'd4: begin
                     mb_r[bitLen-1 -: DBITS] <= rd_data;
                     state <= S_SQR;
                  end
                  default: ;
               endcase
            end
            S_SQR, S_MUL, S_FIN: begin
               if (!mp_last) begin
                  s_r <= s_nxt;
                  j_r <= j_r + 10'd1;
               end else begin
                  x_r <= red;
                  s_r <= '0;
                  j_r <= '0;
                  if (state == S_FIN) begin
                     wr_en   <= 1'b1;
                     wr_addr <= ABITS'(4);
                     wr_data <= red[DBITS-1:0];
                     wr_ph   <= 1'b0;
                     state   <= S_WR;
                  end else if (state == S_SQR && e_r[i_r]) begin
                     state <= S_MUL;
                  end else if (last_bit) begin
                     state <= S_FIN;
                  end else begin
                     i_r   <= i_r - 10'd1;
                     state <= S_SQR;
                  end
               end
            end
            S_WR: begin
               if (!wr_ph) begin
                  wr_addr <= ABITS'(5);
                  wr_data <= x_r[bitLen-1 -: DBITS];
                  wr_ph   <= 1'b1;
               end else begin
                  wr_en <= 1'b0;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               ans   <= {1'b0, x_r};
               stop  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mon_exp_unit.sv
// Scoreboard bench for mon_exp_unit: host preload, exponentiation
// runs, abort, ignored start, and a memory port-collision check.
`timescale 1ns/1ps
module tb_mon_exp_unit;

   localparam int BL = 1024;
   localparam int AB = 8;
   localparam int DB = 512;
   localparam int K  = 10;
   localparam longint MOD  = 589;
   localparam longint BASE = 199;

   typedef struct {
      logic [BL:0] ans;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [BL-1:0] e = '0;
   logic [9:0]    e_idx = '0;
   logic [BL-1:0] M = BL'(MOD);
   logic [9:0]    mp_count = 10'(K);
   logic [AB-1:0] rd_addr, wr_addr;
   logic [DB-1:0] rd_data, wr_data;
   logic          wr_en, stop;
   logic [BL:0]   ans;

   logic [AB-1:0] h_addr = '0, h_rd = '0, mem_rd;
   logic [DB-1:0] h_data = '0;
   logic          h_en = 1'b0, h_sel = 1'b0;

   logic [AB-1:0] b_a1 = '0, b_a2 = '0, b_ra = '0;
   logic [DB-1:0] b_d1 = '0, b_d2 = '0, b_rdata;
   logic          b_e1 = 1'b0, b_e2 = 1'b0;

   assign mem_rd = h_sel ? h_rd : rd_addr;

   always #5 clk = ~clk;

   mon_exp_unit #(.bitLen(BL), .ABITS(AB), .DBITS(DB)) dut (
      .clk(clk), .rst(rst), .start(start), .e(e), .e_idx(e_idx),
      .M(M), .mp_count(mp_count), .rd_addr(rd_addr),
      .rd_data(rd_data), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_en(wr_en), .stop(stop), .ans(ans)
   );

   bram #(.ABITS(AB), .DBITS(DB)) mem (
      .clk(clk), .rst(rst),
      .WR_ADDR1(wr_addr), .WR_DATA1(wr_data), .WR_EN1(wr_en),
      .WR_ADDR2(h_addr), .WR_DATA2(h_data), .WR_EN2(h_en),
      .RD_ADDR(mem_rd), .RD_DATA(rd_data)
   );

   bram #(.ABITS(AB), .DBITS(DB)) mem2 (
      .clk(clk), .rst(rst),
      .WR_ADDR1(b_a1), .WR_DATA1(b_d1), .WR_EN1(b_e1),
      .WR_ADDR2(b_a2), .WR_DATA2(b_d2), .WR_EN2(b_e2),
      .RD_ADDR(b_ra), .RD_DATA(b_rdata)
   );

   task automatic chk(input string tag, input logic [BL:0] got,
                      input logic [BL:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   function automatic longint modpow(longint b, int x);
      longint r = 1;
      for (int i = 0; i < x; i++) r = (r * b) % MOD;
      return r;
   endfunction

   task automatic host_wr(input int a, input int d);
      @(negedge clk);
      h_addr = AB'(a);
      h_data = DB'(d);
      h_en   = 1'b1;
      @(negedge clk);
      h_en   = 1'b0;
   endtask

   task automatic run_op(input int ev, input int ei, input bit poke);
      exp_t x;
      int   n;
      bit   seen;
      int   p;
      p = 0;
      for (int b = 0; b <= ei; b++) p += (ev >> b) & 1;
      x.ans = (BL+1)'(modpow(BASE, ev));
      x.lat = (ei + 1 + p + 1) * (K + 1) + 8;
      sb.push_back(x);
      @(negedge clk);
      e = BL'(ev);
      e_idx = 10'(ei);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("stop_clear", stop, 0);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 2000) begin
         @(posedge clk);
         n++;
         #1;
         if (stop) seen = 1'b1;
         if (poke && n == 50) begin
            e = BL'(1);
            e_idx = 10'd0;
            start = 1'b1;
         end
         if (poke && n == 51) start = 1'b0;
      end
      x = sb.pop_front();
      chk("stop_rise", stop, 1);
      if (seen) begin
         chk("latency", (BL+1)'(n), (BL+1)'(x.lat));
         chk("ans", ans, x.ans);
         h_sel = 1'b1;
         h_rd = AB'(4);
         @(posedge clk);
         #1;
         chk("mem4", rd_data, x.ans[DB-1:0]);
         h_rd = AB'(5);
         @(posedge clk);
         #1;
         chk("mem5", rd_data, x.ans[BL-1:DB]);
         h_sel = 1'b0;
         chk("ans_hold", ans, x.ans);
         chk("stop_hold", stop, 1);
      end
   endtask

   task automatic abort_op();
      @(negedge clk);
      e = BL'(300);
      e_idx = 10'd8;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_stop", stop, 0);
      chk("abort_ans", ans, 0);
      chk("abort_wr_en", wr_en, 0);
      chk("abort_rd_addr", rd_addr, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stop", stop, 0);
      chk("rst_ans", ans, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_rd_data", b_rdata, 0);
      @(negedge clk);
      rst = 1'b0;

      host_wr(0, 435);
      host_wr(1, 0);
      host_wr(2, 571);
      host_wr(3, 0);

      run_op(300, 8, 1'b0);
      run_op(1, 0, 1'b0);
      run_op(2, 1, 1'b0);
      run_op(0, 0, 1'b0);
      abort_op();
      run_op(300, 8, 1'b0);
      run_op(300, 8, 1'b1);

      @(negedge clk);
      b_a1 = AB'(7);
      b_d1 = DB'(32'hA);
      b_e1 = 1'b1;
      b_a2 = AB'(7);
      b_d2 = DB'(32'hB);
      b_e2 = 1'b1;
      @(negedge clk);
      b_e1 = 1'b0;
      b_e2 = 1'b0;
      b_ra = AB'(7);
      @(posedge clk);
      #1;
      chk("mem_collide", b_rdata, (BL+1)'(32'hA));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
